rv_trace_capture: RTL and testbench

RV_TRACE_CAPTURE -- requirements
Module: rv_trace_capture

---
 rtl/rv_trace_pkg.sv | 16 +
 rtl/rv_trace_fifo.sv | 40 ++++
 rtl/rv_trace_capture.sv | 82 ++++++++
 tb/tb_rv_trace_capture.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rv_trace_pkg.sv
// rv_trace_pkg: shared FSM state, halt-cause encodings and trap instruction constants
package rv_trace_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;
  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_EBREAK = 2'b01,
    CAUSE_ECALL  = 2'b10,
    CAUSE_STALL  = 2'b11
  } halt_cause_t;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [31:0] ECALL    = 32'h0000_0073;
  localparam logic [15:0] C_EBREAK = 16'h9002;
  function automatic logic is_rvc(input logic [31:0] instr);
    return instr[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/rv_trace_fifo.sv
// rv_trace_fifo: synchronous FIFO, combinational head read, push accepted when full only alongside a pop
module rv_trace_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          wr, rd;
  assign valid = cnt != '0;
  assign full  = cnt == (AW+1)'(DEPTH);
  assign level = cnt;
  assign dout  = mem[rp];
  assign rd    = pop && valid;
  assign wr    = push && (!full || rd);
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/rv_trace_capture.sv
// rv_trace_capture: captures each distinct core PC/instruction into a FIFO, halting on ebreak/ecall/stall
module rv_trace_capture
  import rv_trace_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 16,
  parameter int STALL_LIMIT = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [XLEN-1:0]          pc_in,
  input  logic [31:0]              instr_in,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [XLEN-1:0]          rd_pc,
  output logic [31:0]              rd_instr,
  output logic                     rd_compressed,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              dropped_count,
  output logic                     halted,
  output logic [1:0]               halt_cause,
  output logic [31:0]              cycle_count
);
  localparam int SW = $clog2(STALL_LIMIT) + 1;
  state_t          state;
  logic [XLEN-1:0] prev_pc;
  logic [SW-1:0]   stall_cnt;
  logic            compressed, push, pop, full, is_ebreak, is_ecall, drop, stall_hit;
  assign compressed = is_rvc(instr_in);
  assign push       = state == S_IDLE || (state == S_RUN && pc_in != prev_pc);
  assign pop        = rd_valid && rd_ready;
  assign drop       = push && full && !pop;
  assign is_ebreak  = instr_in == EBREAK || (compressed && instr_in[15:0] == C_EBREAK);
  assign is_ecall   = instr_in == ECALL;
  assign stall_hit  = state == S_RUN && !push && stall_cnt == SW'(STALL_LIMIT - 1);
  rv_trace_fifo #(.W(XLEN + 33), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     ({compressed, instr_in, pc_in}),
    .dout    ({rd_compressed, rd_instr, rd_pc}),
    .valid   (rd_valid),
    .full    (full),
    .level   (level)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      prev_pc       <= '0;
      stall_cnt     <= '0;
      cycle_count   <= '0;
      overflow      <= 1'b0;
      dropped_count <= '0;
      halted        <= 1'b0;
      halt_cause    <= CAUSE_NONE;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
        if (dropped_count != 16'hFFFF) dropped_count <= dropped_count + 16'd1;
      end
      if (state != S_HALTED) begin
        cycle_count <= cycle_count + 32'd1;
        prev_pc     <= pc_in;
      end
      if (state == S_RUN) stall_cnt <= push ? '0 : stall_cnt + 1'b1;
      // the halting entry itself has already been offered to the FIFO this cycle
      if (push && (is_ebreak || is_ecall)) begin
        state      <= S_HALTED;
        halted     <= 1'b1;
        halt_cause <= is_ebreak ? CAUSE_EBREAK : CAUSE_ECALL;
      end else if (stall_hit) begin
        state      <= S_HALTED;
        halted     <= 1'b1;
        halt_cause <= CAUSE_STALL;
      end else if (state == S_IDLE) begin
        state <= S_RUN;
      end
    end
  end
endmodule

// File: tb/tb_rv_trace_capture.sv
// tb_rv_trace_capture: directed vectors with an expected-entry queue checked by a pop monitor
module tb_rv_trace_capture;
  typedef struct packed {
    logic        c;
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  logic        clk = 0;
  logic        reset_n;
  logic [31:0] pc_in, instr_in;
  logic        rd_ready;
  logic        rd_valid, rd_compressed, overflow, halted;
  logic [31:0] rd_pc, rd_instr, cycle_count;
  logic [4:0]  level;
  logic [15:0] dropped_count;
  logic [1:0]  halt_cause;
  ent_t        exp_q[$];
  int          nvec = 0;
  int          nfail = 0;
  rv_trace_capture #(.XLEN(32), .DEPTH(16), .STALL_LIMIT(64)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc_in         (pc_in),
    .instr_in      (instr_in),
    .rd_ready      (rd_ready),
    .rd_valid      (rd_valid),
    .rd_pc         (rd_pc),
    .rd_instr      (rd_instr),
    .rd_compressed (rd_compressed),
    .level         (level),
    .overflow      (overflow),
    .dropped_count (dropped_count),
    .halted        (halted),
    .halt_cause    (halt_cause),
    .cycle_count   (cycle_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    ent_t e;
    if (reset_n && rd_valid && rd_ready) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_entry pc=%h instr=%h c=%b, none expected", rd_pc, rd_instr, rd_compressed);
      end else begin
        e = exp_q.pop_front();
        if (rd_pc !== e.pc || rd_instr !== e.instr || rd_compressed !== e.c) begin
          nfail++;
          $display("FAIL entry got pc=%h instr=%h c=%b expected pc=%h instr=%h c=%b",
                   rd_pc, rd_instr, rd_compressed, e.pc, e.instr, e.c);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic step(input logic [31:0] pc, input logic [31:0] instr, input bit push, input bit c);
    pc_in = pc;
    instr_in = instr;
    if (push) exp_q.push_back({c, instr, pc});
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rd_ready = 0;
    reset_n  = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1;
  endtask
  task automatic drain();
    rd_ready = 1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask
  initial begin
    reset_n = 0; rd_ready = 0; pc_in = 0; instr_in = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", rd_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cause", halt_cause, 0);
    chk("rst_cycles", cycle_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_dropped", dropped_count, 0);
    // basic capture, compressed flags 1/0/1/0
    reset_n = 1;
    rd_ready = 1;
    step(32'h0, 32'h0000_4501, 1, 1);
    step(32'h4, 32'h0000_0013, 1, 0);
    step(32'h6, 32'h0000_0505, 1, 1);
    step(32'hA, 32'h00a0_0093, 1, 0);
    chk("t1_cycles", cycle_count, 4);
    chk("t1_halted", halted, 0);
    drain();
    chk("t1_level", level, 0);
    // ebreak halts, later PCs ignored
    do_reset();
    rd_ready = 1;
    step(32'hC, 32'h0000_0013, 1, 0);
    step(32'h10, 32'h0010_0073, 1, 0);
    chk("t2_halted", halted, 1);
    chk("t2_cause", halt_cause, 2'b01);
    step(32'h14, 32'h0000_0013, 0, 0);
    step(32'h18, 32'h0000_0013, 0, 0);
    drain();
    chk("t2_level", level, 0);
    // c.ebreak on the very first capture
    do_reset();
    rd_ready = 1;
    step(32'h40, 32'h0000_9002, 1, 1);
    chk("t2c_halted", halted, 1);
    chk("t2c_cause", halt_cause, 2'b01);
    drain();
    // stall: 64 unchanged cycles after PC reaches 0x20
    do_reset();
    rd_ready = 1;
    step(32'h1C, 32'h0000_0013, 1, 0);
    step(32'h20, 32'h0000_0013, 1, 0);
    repeat (63) step(32'h20, 32'h0000_0013, 0, 0);
    chk("t3_not_yet", halted, 0);
    step(32'h20, 32'h0000_0013, 0, 0);
    chk("t3_halted", halted, 1);
    chk("t3_cause", halt_cause, 2'b11);
    chk("t3_cycles", cycle_count, 66);
    repeat (10) step(32'h24, 32'h0000_0013, 0, 0);
    chk("t3_frozen", cycle_count, 66);
    chk("t3_drained", exp_q.size(), 0);
    // overflow with 20 pushes into a 16-deep FIFO
    do_reset();
    for (int i = 0; i < 20; i++) step(32'h100 + 32'(4 * i), 32'h0000_0013, i < 16, 0);
    chk("t4_level", level, 16);
    chk("t4_overflow", overflow, 1);
    chk("t4_dropped", dropped_count, 4);
    rd_ready = 1;
    step(32'h200, 32'h0000_0013, 1, 0);
    rd_ready = 0;
    chk("t4_level_full", level, 16);
    chk("t4_dropped_same", dropped_count, 4);
    drain();
    // reset with 5 entries queued after ecall
    do_reset();
    for (int i = 0; i < 4; i++) step(32'h300 + 32'(4 * i), 32'h0000_0013, 1, 0);
    step(32'h310, 32'h0000_0073, 1, 0);
    chk("t5_halted", halted, 1);
    chk("t5_cause", halt_cause, 2'b10);
    step(32'h314, 32'h0000_0013, 0, 0);
    chk("t5_level", level, 5);
    reset_n = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("t5_valid", rd_valid, 0);
    chk("t5_level0", level, 0);
    chk("t5_halted0", halted, 0);
    chk("t5_cycles0", cycle_count, 0);
    chk("t5_cause0", halt_cause, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout reached before completion");
    $fatal(1, "timeout");
  end
endmodule
